// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, per-channel stability counter,
// debounced level plus one-cycle press/release pulses. `release` is a reserved word, hence release_pulse.
module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 16,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_tick,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic            any_press
);

  localparam int            CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic          IDLE = ACTIVE_LOW;

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] p;
  logic [CW-1:0]   cnt [N_CH];

  // Synchroniser idles at the released pin value so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= {N_CH{IDLE}};
      s2 <= {N_CH{IDLE}};
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  assign p = ACTIVE_LOW ? ~s2 : s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      press         <= '0;
      release_pulse <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        // A sample matching the accepted level clears the count regardless of the tick.
        if (p[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (sample_tick) begin
          if (cnt[i] == LAST) begin
            level[i]         <= p[i];
            cnt[i]           <= '0;
            press[i]         <= p[i];
            release_pulse[i] <= ~p[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign any_press = |press;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank (4 channels, 4 stable samples, active-low pins).
module tb_debounce_bank;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic [3:0] btn_raw;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] release_pulse;
  logic       any_press;

  debounce_bank #(
    .N_CH(4),
    .STABLE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_tick(sample_tick),
    .btn_raw(btn_raw),
    .level(level),
    .press(press),
    .release_pulse(release_pulse),
    .any_press(any_press)
  );

  typedef struct {
    int       edge_at;
    logic [3:0] prs;
    logic [3:0] rls;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [3:0] exp_level;
  int         edge_no;
  int         checks;
  int         errors;
  bit         prescale;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Tick for the upcoming edge: every edge, or only edges divisible by 4.
  always @(negedge clk) sample_tick = prescale ? (((edge_no + 1) % 4) == 0) : 1'b1;

  function automatic int accept_at(input int r);
    int t;
    int n;
    t = r + 3;
    n = 0;
    while (1) begin
      if (!prescale || (t % 4) == 0) n++;
      if (n == 4) return t;
      t++;
    end
  endfunction

  // Scoreboard: pop expectations at the edge they are due, otherwise expect silence.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].edge_at < edge_no) begin
      checks++;
      errors++;
      $display("FAIL missed_event: edge %0d got nothing, expected press=%b rel=%b", q[0].edge_at, q[0].prs, q[0].rls);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].edge_at == edge_no) begin
      cur = q.pop_front();
      checks++;
      if (press !== cur.prs || release_pulse !== cur.rls || any_press !== (|cur.prs)) begin
        errors++;
        $display("FAIL pulse@%0d: got press=%b rel=%b any=%b, expected press=%b rel=%b any=%b",
                 edge_no, press, release_pulse, any_press, cur.prs, cur.rls, |cur.prs);
      end
      exp_level = (exp_level | cur.prs) & ~cur.rls;
    end else begin
      checks++;
      if (press !== 4'b0000 || release_pulse !== 4'b0000 || any_press !== 1'b0) begin
        errors++;
        $display("FAIL unexpected_pulse@%0d: got press=%b rel=%b any=%b, expected all 0",
                 edge_no, press, release_pulse, any_press);
      end
    end
    checks++;
    if (level !== exp_level) begin
      errors++;
      $display("FAIL level@%0d: got %b, expected %b", edge_no, level, exp_level);
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending events, expected 0", name, q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic drive(input int ch, input logic v, input logic [3:0] prs, input logic [3:0] rls);
    exp_t x;
    @(negedge clk);
    btn_raw[ch] = v;
    x.edge_at = accept_at(edge_no);
    x.prs = prs;
    x.rls = rls;
    q.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn_raw = 4'hF;
    #2;
    checks++;
    if (level !== 4'b0 || press !== 4'b0 || release_pulse !== 4'b0 || any_press !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got level=%b press=%b rel=%b any=%b, expected all 0",
               level, press, release_pulse, any_press);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_clean_press();
    drive(2, 1'b0, 4'b0100, 4'b0000);
    drain("clean_press");
    drive(2, 1'b1, 4'b0000, 4'b0100);
    drain("clean_release");
  endtask

  task automatic test_bounce();
    exp_t x;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = ~btn_raw[0];
      repeat (2) @(negedge clk);
    end
    checks++;
    if (level[0] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_level: got %b, expected 0", level[0]);
    end
    btn_raw[0] = 1'b0;
    x.edge_at = edge_no + 6;
    x.prs = 4'b0001;
    x.rls = 4'b0000;
    q.push_back(x);
    drain("bounce_press");
    drive(0, 1'b1, 4'b0000, 4'b0001);
    drain("bounce_release");
  endtask

  task automatic test_release();
    drive(1, 1'b0, 4'b0010, 4'b0000);
    drain("release_setup");
    drive(1, 1'b1, 4'b0000, 4'b0010);
    drain("release");
  endtask

  task automatic test_prescaled();
    int   e;
    exp_t x;
    prescale = 1'b1;
    @(negedge clk);
    while ((edge_no % 4) != 1) @(negedge clk);
    e = edge_no;
    btn_raw[3] = 1'b0;
    while (edge_no != e + 7) @(negedge clk);
    btn_raw[3] = 1'b1;
    @(negedge clk);
    btn_raw[3] = 1'b0;
    x.edge_at = accept_at(edge_no);
    x.prs = 4'b1000;
    x.rls = 4'b0000;
    q.push_back(x);
    drain("prescaled_press");
    drive(3, 1'b1, 4'b0000, 4'b1000);
    drain("prescaled_release");
    prescale = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    exp_t x;
    @(negedge clk);
    btn_raw = 4'b0110;
    x.edge_at = edge_no + 6;
    x.prs = 4'b1001;
    x.rls = 4'b0000;
    q.push_back(x);
    drain("simultaneous");
  endtask

  task automatic test_reset_mid();
    exp_t x;
    drive(1, 1'b0, 4'b0010, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_level = 4'b0000;
    #1;
    checks++;
    if (level !== 4'b0 || press !== 4'b0 || release_pulse !== 4'b0 || any_press !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got level=%b press=%b rel=%b any=%b, expected all 0",
               level, press, release_pulse, any_press);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    x.edge_at = edge_no + 6;
    x.prs = 4'b1011;
    x.rls = 4'b0000;
    q.push_back(x);
    drain("reset_held_press");
    @(negedge clk);
    btn_raw = 4'hF;
    x.edge_at = edge_no + 6;
    x.prs = 4'b0000;
    x.rls = 4'b1011;
    q.push_back(x);
    drain("reset_release_all");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    edge_no = 0;
    prescale = 1'b0;
    exp_level = 4'b0000;
    sample_tick = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_prescaled();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button conditioner for the safe's keypad and control buttons. Each channel synchronises a raw asynchronous button input, filters contact bounce with a per-channel stability counter, and produces a clean debounced level plus single-cycle press and release pulses. It sits between the board pins and the lock/timer control FSMs, replacing single-flop edge detection with a bounce-tolerant, N-wide bank.

## Interface
- `N_CH`, default 4: number of independent button channels (≥1).
- `STABLE_CYCLES`, default 16: counted samples a new input value must hold before it is accepted (≥1). Counter width is max(1, $clog2(STABLE_CYCLES)).
- `ACTIVE_LOW`, default 1: 1 means a pin reads 0 when pressed, 0 means a pin reads 1 when pressed.
- `clk` input, 1 bit: single system clock; all state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `sample_tick` input, 1 bit: counter advance qualifier (prescaler strobe); tie to 1 to count every clock.
- `btn_raw` input, N_CH bits: raw asynchronous button pins.
- `level` output, N_CH bits: debounced state per channel, 1 = pressed.
- `press` output, N_CH bits: one-cycle pulse when `level[i]` goes 0→1.
- `release` output, N_CH bits: one-cycle pulse when `level[i]` goes 1→0.
- `any_press` output, 1 bit: OR-reduction of `press`.

## Operation
- **Reset** (`rst`=0, asynchronous): `level`, `press`, `release`, `any_press` = 0; counters = 0; both synchroniser flops = idle pin value (1 if ACTIVE_LOW, else 0).
- **Synchroniser**: per channel, 2-flop chain `s1 <= btn_raw[i]`, `s2 <= s1`. Polarity-corrected sample `p = ACTIVE_LOW ? ~s2 : s2`.
- **Filter** (per channel, every rising edge):
  - If `p == level[i]`: clear the counter. No pulse.
  - Else if `sample_tick`=0: hold the counter. No pulse.
  - Else if counter == STABLE_CYCLES-1: `level[i] <= p`, clear the counter, and assert `press[i]` (if p=1) or `release[i]` (if p=0) for one cycle.
  - Else: increment the counter.
- `press` and `release` are registered and default to 0 each cycle. They never assert together on one channel. Channels are fully independent; multiple channels may pulse in the same cycle.
- Any single bounce back to the accepted value (`p == level`) clears the count, even with `sample_tick` low. A changed value that does not hold for a full run of counted samples is never accepted.
- A button held through reset release is reported as a fresh press after the normal latency.
- Counter never exceeds STABLE_CYCLES-1; no wrap.

## Timing
- With `sample_tick`=1: a steady change on `btn_raw[i]` first captured into `s1` at edge k gives `level[i]` and its pulse updating at edge k+1+STABLE_CYCLES. Total latency is STABLE_CYCLES+2 edges including edge k.
- With a prescaled `sample_tick`: acceptance occurs at the STABLE_CYCLES-th ticked edge after `s2` holds the new value.
- `press` and `release` are high for exactly one clock, in the same cycle `level` first shows the new value.
- `any_press` is combinational from the `press` registers, with zero added latency.
- Asynchronous reset mid-count forces all outputs low immediately. Counting restarts from 0 after deassertion.

## Test plan
- **Clean press**: N_CH=4, STABLE_CYCLES=4, ACTIVE_LOW=1, tick=1; drive `btn_raw[2]` 1→0 before edge 0 → `level[2]`=1 and `press`=4'b0100 for exactly one cycle after edge 5; `any_press`=1 in that cycle only; other channels stay 0.
- **Bounce rejection**: toggle `btn_raw[0]` 0/1 every 2 cycles for 20 cycles → no pulses, `level[0]` stays 0. Then hold 0 → press pulse exactly 6 edges after the last transition is sampled.
- **Release**: from `level[1]`=1, drive `btn_raw[1]` high → `release[1]` pulses once after 6 edges, `level[1]`=0, `press[1]` never asserts.
- **Prescaled**: tick every 4th cycle, STABLE_CYCLES=4 → acceptance at the 4th tick after `s2` changes. A bounce between ticks clears the count.
- **Simultaneous/reset**: press channels 0 and 3 on the same edge → `press`=4'b1001 in one cycle. Assert `rst` low mid-count → all outputs 0 asynchronously. Button still held after release → press reported 6 edges after `rst` deasserts.
